// File: rtl/score_display_scanner_pkg.sv
// Shared types and helpers for the score display scanner: BCD digit type,
// blank code and converter state encoding.
package score_display_scanner_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Double-dabble correction applied to one nibble before each shift.
  function automatic bcd_t dabble_adj(input bcd_t d);
    return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/score_display_scanner_bin2bcd_seq.sv
// Sequential double-dabble converter with saturation, a one-entry pending
// buffer and an atomically committed digit register bank.
module bin2bcd_seq
  import score_display_scanner_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCORE_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_valid,
  output logic                    busy,
  output logic [4*N_DIGITS-1:0]   digits
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(SCORE_W - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(10 ** N_DIGITS - 1);

  conv_state_t          state_r;
  logic [SCORE_W-1:0]   bin_r;
  logic [BCD_W-1:0]     bcd_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 pend_r;
  logic [SCORE_W-1:0]   pend_val_r;
  logic                 busy_r;
  logic [BCD_W-1:0]     digits_r;

  logic [SCORE_W-1:0]   clamped_s;
  logic [BCD_W-1:0]     adj_s;
  logic [BCD_W-1:0]     bcd_shift_s;
  logic [SCORE_W-1:0]   bin_shift_s;

  // Saturate, then one double-dabble iteration on the current accumulator.
  always_comb begin
    clamped_s = (score > MAX_SCORE) ? MAX_SCORE : score;
    adj_s     = bcd_r;
    for (int i = 0; i < N_DIGITS; i++) begin
      adj_s[4*i +: 4] = dabble_adj(bcd_r[4*i +: 4]);
    end
    bcd_shift_s = {adj_s[BCD_W-2:0], bin_r[SCORE_W-1]};
    bin_shift_s = {bin_r[SCORE_W-2:0], 1'b0};
  end

  // Converter FSM: load, SCORE_W shifts, commit; busy bridges a pending restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      bin_r    <= {SCORE_W{1'b0}};
      bcd_r    <= {BCD_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      digits_r <= {BCD_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (score_valid || pend_r) begin
            bin_r   <= score_valid ? clamped_s : pend_val_r;
            bcd_r   <= {BCD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          bin_r <= bin_shift_s;
          bcd_r <= bcd_shift_s;
          if (cnt_r == LAST_CNT) begin
            state_r <= COMMIT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        COMMIT: begin
          digits_r <= bcd_r;
          busy_r   <= pend_r | score_valid;
          state_r  <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Pending buffer: latest request during a conversion wins; IDLE consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r     <= 1'b0;
      pend_val_r <= {SCORE_W{1'b0}};
    end else if (score_valid && (state_r != IDLE)) begin
      pend_r     <= 1'b1;
      pend_val_r <= clamped_s;
    end else if (state_r == IDLE) begin
      pend_r     <= 1'b0;
    end else begin
      pend_r     <= pend_r;
    end
  end

  assign busy   = busy_r;
  assign digits = digits_r;

endmodule

// File: rtl/score_display_scanner.sv
// Score display front end: BCD conversion plus a free-running digit scanner
// driving one shared decoder input with active-low anodes and zero blanking.
module score_display_scanner
  import score_display_scanner_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SCORE_W     = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SCORE_W-1:0]   score,
  input  logic                 score_valid,
  output logic                 busy,
  output logic [3:0]           digit_val,
  output logic [N_DIGITS-1:0]  anode_n
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_RST  = ~(N_DIGITS'(1));

  logic [4*N_DIGITS-1:0] digits_s;
  logic [PRESC_W-1:0]    presc_r;
  logic [IDX_W-1:0]      digit_idx_r;
  logic                  nz_s;
  bcd_t                  cur_s;
  bcd_t                  sel_digit_s;
  logic [N_DIGITS-1:0]   sel_anode_s;

  bin2bcd_seq #(
    .N_DIGITS (N_DIGITS),
    .SCORE_W  (SCORE_W)
  ) u_conv (
    .clk         (clk),
    .rst_n       (rst_n),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .digits      (digits_s)
  );

  // Prescaler and digit index; runs regardless of converter activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r     <= {PRESC_W{1'b0}};
      digit_idx_r <= {IDX_W{1'b0}};
    end else if (presc_r == PRESC_LAST) begin
      presc_r     <= {PRESC_W{1'b0}};
      digit_idx_r <= (digit_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : digit_idx_r + IDX_W'(1);
    end else begin
      presc_r     <= presc_r + PRESC_W'(1);
    end
  end

  // Walk from the top digit down so nz_s marks "this or a higher digit is nonzero".
  always_comb begin
    nz_s        = 1'b0;
    cur_s       = 4'd0;
    sel_digit_s = BCD_BLANK;
    sel_anode_s = {N_DIGITS{1'b1}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      cur_s = digits_s[4*i +: 4];
      nz_s  = nz_s | (cur_s != 4'd0);
      if (digit_idx_r == IDX_W'(i)) begin
        sel_digit_s = (nz_s || (i == 0)) ? cur_s : BCD_BLANK;
        sel_anode_s = ~(N_DIGITS'(1) << i);
      end else begin
        sel_digit_s = sel_digit_s;
      end
    end
  end

  // Digit value and anode share one register stage so they always move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val <= 4'd0;
      anode_n   <= ANODE_RST;
    end else begin
      digit_val <= sel_digit_s;
      anode_n   <= sel_anode_s;
    end
  end

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed bench for score_display_scanner with a fast refresh divider.
module tb_score_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] score;
  logic        score_valid;
  logic        busy;
  logic [3:0]  digit_val;
  logic [3:0]  anode_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] score;
    logic [15:0] exp;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[10];

  score_display_scanner #(
    .N_DIGITS    (4),
    .SCORE_W     (14),
    .REFRESH_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .digit_val   (digit_val),
    .anode_n     (anode_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int anode_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Observe 24 cycles: every anode value legal, order 0..3 with 4-cycle dwell, digits match.
  task automatic scan(input string name, input logic [15:0] exp);
    logic [15:0] got = 16'h0000;
    logic [3:0]  seen = 4'h0;
    int prev = -1;
    int run = 0;
    int idx;
    bit first = 1'b1;
    bit bad_anode = 1'b0;
    bit bad_seq = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      idx = anode_idx(anode_n);
      if (idx < 0) begin
        bad_anode = 1'b1;
      end else begin
        got[4*idx +: 4] = digit_val;
        seen[idx] = 1'b1;
        if (prev < 0) begin
          run = 1;
        end else if (idx == prev) begin
          run++;
        end else begin
          if (idx != (prev + 1) % 4) bad_seq = 1'b1;
          if (!first && run != 4) bad_seq = 1'b1;
          first = 1'b0;
          run = 1;
        end
        prev = idx;
      end
    end
    check($sformatf("%s anode_legal", name), 32'(bad_anode), 32'd0);
    check($sformatf("%s scan_order", name), 32'(bad_seq), 32'd0);
    check($sformatf("%s all_digits_seen", name), 32'(seen), 32'hF);
    check($sformatf("%s digits", name), 32'(got), 32'(exp));
  endtask

  // Pulse score_valid for one cycle and count cycles with busy high.
  task automatic send(input logic [13:0] s, output int nbusy);
    score = s;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb;
    int idx;
    bit seen12;
    bit seen34;

    vecs[0] = '{14'd1234,  16'h1234};
    vecs[1] = '{14'd7,     16'hFFF7};
    vecs[2] = '{14'd0,     16'hFFF0};
    vecs[3] = '{14'd1005,  16'h1005};
    vecs[4] = '{14'h3FFF,  16'h9999};
    vecs[5] = '{14'd10000, 16'h9999};
    vecs[6] = '{14'd9999,  16'h9999};
    vecs[7] = '{14'd10,    16'hFF10};
    vecs[8] = '{14'd5090,  16'h5090};
    vecs[9] = '{14'd100,   16'hF100};

    rst_n = 1'b0;
    score = 14'd0;
    score_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset anode_n", 32'(anode_n), 32'h E);
    check("reset digit_val", 32'(digit_val), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    scan("after_reset", 16'hFFF0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].score, nb);
      check($sformatf("score_%0d busy_cycles", vecs[i].score), 32'(nb), 32'd15);
      @(negedge clk);
      scan($sformatf("score_%0d", vecs[i].score), vecs[i].exp);
    end

    // Back-to-back: 12 in IDLE, 34 and 56 while busy; only 12 and 56 may appear.
    seen12 = 1'b0;
    seen34 = 1'b0;
    nb = 0;
    for (int c = 0; c < 46; c++) begin
      score_valid = (c == 0) || (c == 3) || (c == 5);
      score = (c == 0) ? 14'd12 : (c == 3) ? 14'd34 : 14'd56;
      @(negedge clk);
      if (busy) nb++;
      idx = anode_idx(anode_n);
      if ((idx == 0 && digit_val == 4'd2) || (idx == 1 && digit_val == 4'd1)) seen12 = 1'b1;
      if ((idx == 0 && digit_val == 4'd4) || (idx == 1 && digit_val == 4'd3)) seen34 = 1'b1;
    end
    score_valid = 1'b0;
    check("b2b busy_cycles", 32'(nb), 32'd31);
    check("b2b 12_displayed", 32'(seen12), 32'd1);
    check("b2b 34_displayed", 32'(seen34), 32'd0);
    scan("b2b_final", 16'hFF56);

    // Reset in the middle of converting 4321.
    score = 14'd4321;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("midconv busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midconv reset anode_n", 32'(anode_n), 32'hE);
    check("midconv reset digit_val", 32'(digit_val), 32'h0);
    check("midconv reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midconv busy_after", 32'(busy), 32'h0);
    scan("midconv_after_reset", 16'hFFF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
